wb_uart_host: RTL
=================

// Module: wb_uart_host
// PURPOSE
//  Wishbone slave that drives the ASCII bus-access protocol as the initiator and parses the target's replies.
//  One wishbone cycle becomes a UART byte sequence. The remote uart2wb target performs the access.
//  Sits between a local wishbone master and a UART TX/RX pair.
//  Protocol: '.' resync; 'p'+6 hex nibbles sets address; 'w'+2 nibbles writes; 'r' reads.
//  Hex digits are uppercase ASCII. Address nibble order: [7:4],[3:0],[15:12],[11:8],[23:20],[19:16].
// PARAMETERS
//  RESP_TIMEOUT  100000  clocks to wait for any expected reply byte before aborting
// PORTS
//  i_wb_clk    in   1   single clock
//  i_wb_rst_n  in   1   reset, asynchronous, active-low
//  i_wb_cyc    in   1   wishbone cycle
//  i_wb_stb    in   1   wishbone strobe
//  i_wb_we     in   1   1=write, 0=read
//  i_wb_adr    in   24  byte address
//  i_wb_dat    in   8   write data
//  o_wb_dat    out  8   read data, valid while o_wb_ack=1
//  o_wb_ack    out  1   one-cycle completion pulse
//  o_wb_err    out  1   one-cycle abort pulse
//  o_tx_dat    out  8   byte to UART transmitter
//  o_send      out  1   one-cycle pulse, only when i_tx_busy=0
//  i_tx_busy   in   1   transmitter busy
//  i_rx_dat    in   8   received byte
//  i_received  in   1   one-cycle pulse, i_rx_dat valid
// BEHAVIOUR
//  Reset values: o_wb_dat=0, o_wb_ack=0, o_wb_err=0, o_tx_dat=0, o_send=0.
//  Reset also forces state IDLE, sets need_resync=1 and clears addr_valid.
//  Reset asserted mid-sequence aborts immediately; no ack or err is issued.
//  IDLE: i_wb_cyc&i_wb_stb starts a transaction. Address and data are latched that cycle.
//  If need_resync: send '.' first (no reply expected), then clear need_resync.
//  SEND_P -> WAIT_P: expect echo 'p'.
//  SEND_NIB x2 -> WAIT_K: repeat 3x, one 'k' expected per address byte. Then addr_valid=1.
//  Write: SEND_W -> WAIT_W ('w') -> SEND_NIB hi,lo -> WAIT_K.
//   'k' => o_wb_ack; 'n' => o_wb_err.
//  Read: SEND_R -> WAIT_R ('r') -> WAIT_HI -> WAIT_LO (hex digits).
//   o_wb_dat={hi,lo} and o_wb_ack pulse in the same cycle.
//  Each SEND state emits exactly one o_send pulse, then advances. Stalls while i_tx_busy=1.
//  Timeout counter reloads on every o_send and counts in WAIT states only.
//  Abort on any of: expiry, 'n', a non-expected byte, or a non-hex digit in a read.
//   Action: o_wb_err pulse, need_resync=1, addr_valid=0, state IDLE.
//  i_received outside WAIT states: byte dropped.
//  i_received in the same cycle as the state entering WAIT: byte is evaluated.
//  i_wb_cyc dropping mid-sequence: the UART sequence completes (keeps the target in sync).
//   The final ack/err is suppressed.
//  Ack/err occurs at most once per transaction. The next request is accepted no earlier than the cycle after ack/err.
// CONFIGURATION
//  ADDR_CACHE_EN defined: the address phase is skipped when addr_valid and i_wb_adr equals the last sent address.
//   The target's address register is assumed unchanged while addr_valid=1.
//  ADDR_CACHE_EN undefined: every transaction sends the full 'p' phase; the cache register is absent.
// STRUCTURE
//  Package wb_uart_pkg holds ASCII constants ('.','p','w','r','k','n'), the state encoding and RESP_TIMEOUT width.
//  Sub-module hex_nibble_codec (combinational): nibble->ASCII and ASCII->{valid,nibble}.
//  The remaining FSM, timeout counter and nibble index stay in wb_uart_host.
// TESTING
//  Reset, then write 0x123456=0xA5.
//   Expect TX '.','p','5','6','3','4','1','2','w','A','5'.
//   Reply 'p','k','k','k','w','k' -> one o_wb_ack.
//  Read 0x000010, target replies 'r','3','C' -> o_wb_dat=0x3C with o_wb_ack; no '.' sent.
//  Write with reply 'n' -> o_wb_err.
//   Next access starts with '.'; with ADDR_CACHE_EN, 'p' is re-sent.
//  No reply after 'p' -> o_wb_err exactly RESP_TIMEOUT clocks after that o_send.
//  i_tx_busy held high 50 clocks -> o_send held off, then one pulse per byte with no duplicates.
//  ADDR_CACHE_EN: two reads of 0x000010 -> second TX is only 'r'.
//   i_wb_cyc dropped mid-read -> sequence completes, no ack.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared constants for the wishbone-to-UART host: protocol ASCII codes, FSM encoding and
// timeout counter width.
package wb_uart_pkg;

  localparam logic [7:0] ChSync = 8'h2E;  // '.'
  localparam logic [7:0] ChP    = 8'h70;  // 'p'
  localparam logic [7:0] ChW    = 8'h77;  // 'w'
  localparam logic [7:0] ChR    = 8'h72;  // 'r'
  localparam logic [7:0] ChK    = 8'h6B;  // 'k'
  localparam logic [7:0] ChN    = 8'h6E;  // 'n'

  localparam int unsigned RESP_TIMEOUT_DEF = 100000;
  // Counter width sized for the default timeout; overrides must not exceed 2**TO_W - 1.
  localparam int unsigned TO_W = $clog2(RESP_TIMEOUT_DEF + 1);

  typedef enum logic [3:0] {
    StIdle,
    StSendSync,
    StSendP,
    StWaitP,
    StSendNib,
    StWaitAk,
    StSendW,
    StWaitW,
    StWaitDk,
    StSendR,
    StWaitR,
    StWaitHi,
    StWaitLo
  } state_e;

endpackage

// File: rtl/wb_uart_host_if.sv
// Wishbone slave-side bus bundle for wb_uart_host.
interface wb_uart_host_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [23:0] i_wb_adr;
  logic [7:0]  i_wb_dat;
  logic [7:0]  o_wb_dat;
  logic        o_wb_ack;
  logic        o_wb_err;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat,
    output o_wb_dat, o_wb_ack, o_wb_err
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/hex_nibble_codec.sv
// Combinational uppercase-hex codec: nibble to ASCII, and ASCII to {valid, nibble}.
module hex_nibble_codec (
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o,
  input  logic [7:0] ascii_i,
  output logic       valid_o,
  output logic [3:0] nib_o
);

  always_comb begin
    ascii_o = (nib_i < 4'd10) ? (8'h30 + {4'h0, nib_i}) : (8'h37 + {4'h0, nib_i});
  end

  always_comb begin
    valid_o = 1'b0;
    nib_o   = 4'h0;
    if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      valid_o = 1'b1;
      nib_o   = ascii_i[3:0];
    end else if (ascii_i >= 8'h41 && ascii_i <= 8'h46) begin
      valid_o = 1'b1;
      nib_o   = ascii_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/wb_uart_host.sv
// Wishbone slave that turns each bus cycle into an ASCII UART exchange with a uart2wb target.
// Build option ADDR_CACHE_EN skips the address phase when the target already holds the address.
module wb_uart_host
  import wb_uart_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  wb_uart_host_if.slave wb,
  output logic [7:0]    o_tx_dat,
  output logic          o_send,
  input  logic          i_tx_busy,
  input  logic [7:0]    i_rx_dat,
  input  logic          i_received
);

  localparam logic [TO_W-1:0] CntMax = TO_W'(RESP_TIMEOUT - 1);

  state_e state_q, state_d;
  logic need_resync_q, need_resync_d, addr_valid_q, addr_valid_d, live_q, live_d;
  logic we_q, we_d, send_q, send_d, ack_q, ack_d, err_q, err_d;
  logic [23:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d, tx_dat_q, tx_dat_d, rdat_q, rdat_d;
  logic [3:0] hi_q, hi_d, nib_sel, rx_nib;
  logic [2:0] idx_q, idx_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0] nib_ascii;
  logic rx_hex_ok, tx_ready, in_wait, abort, cache_hit;
`ifdef ADDR_CACHE_EN
  logic [23:0] last_adr_q, last_adr_d;
`endif

  hex_nibble_codec u_codec (
    .nib_i   (nib_sel),
    .ascii_o (nib_ascii),
    .ascii_i (i_rx_dat),
    .valid_o (rx_hex_ok),
    .nib_o   (rx_nib)
  );

  always_comb begin
    case (idx_q)
      3'd0:    nib_sel = adr_q[7:4];
      3'd1:    nib_sel = adr_q[3:0];
      3'd2:    nib_sel = adr_q[15:12];
      3'd3:    nib_sel = adr_q[11:8];
      3'd4:    nib_sel = adr_q[23:20];
      3'd5:    nib_sel = adr_q[19:16];
      3'd6:    nib_sel = dat_q[7:4];
      default: nib_sel = dat_q[3:0];
    endcase
  end

`ifdef ADDR_CACHE_EN
  assign cache_hit = addr_valid_q && (wb.i_wb_adr == last_adr_q);
`else
  assign cache_hit = 1'b0;
`endif

  // The gap after each pulse lets the transmitter raise busy before the next byte.
  assign tx_ready = !i_tx_busy && !send_q;
  assign in_wait  = state_q inside {StWaitP, StWaitAk, StWaitW, StWaitDk, StWaitR, StWaitHi,
                                    StWaitLo};

  always_comb begin
    state_d       = state_q;
    need_resync_d = need_resync_q;
    addr_valid_d  = addr_valid_q;
    live_d        = live_q;
    we_d          = we_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    tx_dat_d      = tx_dat_q;
    rdat_d        = rdat_q;
    hi_d          = hi_q;
    idx_d         = idx_q;
    cnt_d         = in_wait ? cnt_q + 1'b1 : cnt_q;
    send_d        = 1'b0;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    abort         = 1'b0;
`ifdef ADDR_CACHE_EN
    last_adr_d    = last_adr_q;
`endif
    // A master that leaves mid-sequence still gets the UART exchange finished, silently.
    if (state_q != StIdle && !wb.i_wb_cyc) live_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (wb.i_wb_cyc && wb.i_wb_stb && !ack_q && !err_q) begin
          we_d   = wb.i_wb_we;
          adr_d  = wb.i_wb_adr;
          dat_d  = wb.i_wb_dat;
          live_d = 1'b1;
          idx_d  = 3'd0;
          if (need_resync_q)  state_d = StSendSync;
          else if (cache_hit) state_d = wb.i_wb_we ? StSendW : StSendR;
          else                state_d = StSendP;
        end
      end
      StSendSync: if (tx_ready) begin
        send_d = 1'b1; tx_dat_d = ChSync; cnt_d = '0;
        need_resync_d = 1'b0;
        state_d = StSendP;
      end
      StSendP: if (tx_ready) begin
        send_d = 1'b1; tx_dat_d = ChP; cnt_d = '0;
        state_d = StWaitP;
      end
      StWaitP: if (i_received) begin
        if (i_rx_dat == ChP) state_d = StSendNib;
        else                 abort = 1'b1;
      end
      StSendNib: if (tx_ready) begin
        send_d = 1'b1; tx_dat_d = nib_ascii; cnt_d = '0;
        idx_d = idx_q + 3'd1;
        if (idx_q[0]) state_d = (idx_q == 3'd7) ? StWaitDk : StWaitAk;
      end
      StWaitAk: if (i_received) begin
        if (i_rx_dat != ChK) begin
          abort = 1'b1;
        end else if (idx_q == 3'd6) begin
          addr_valid_d = 1'b1;
`ifdef ADDR_CACHE_EN
          last_adr_d = adr_q;
`endif
          state_d = we_q ? StSendW : StSendR;
        end else begin
          state_d = StSendNib;
        end
      end
      StSendW: if (tx_ready) begin
        send_d = 1'b1; tx_dat_d = ChW; cnt_d = '0;
        state_d = StWaitW;
      end
      StWaitW: if (i_received) begin
        if (i_rx_dat == ChW) begin
          idx_d = 3'd6;
          state_d = StSendNib;
        end else begin
          abort = 1'b1;
        end
      end
      StWaitDk: if (i_received) begin
        if (i_rx_dat == ChK) begin
          ack_d = live_d;
          state_d = StIdle;
        end else begin
          abort = 1'b1;
        end
      end
      StSendR: if (tx_ready) begin
        send_d = 1'b1; tx_dat_d = ChR; cnt_d = '0;
        state_d = StWaitR;
      end
      StWaitR: if (i_received) begin
        if (i_rx_dat == ChR) state_d = StWaitHi;
        else                 abort = 1'b1;
      end
      StWaitHi: if (i_received) begin
        if (rx_hex_ok) begin
          hi_d = rx_nib;
          state_d = StWaitLo;
        end else begin
          abort = 1'b1;
        end
      end
      StWaitLo: if (i_received) begin
        if (rx_hex_ok) begin
          rdat_d = {hi_q, rx_nib};
          ack_d = live_d;
          state_d = StIdle;
        end else begin
          abort = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort || (in_wait && !i_received && cnt_q == CntMax)) begin
      err_d         = live_d;
      ack_d         = 1'b0;
      need_resync_d = 1'b1;
      addr_valid_d  = 1'b0;
      state_d       = StIdle;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q       <= StIdle;
      need_resync_q <= 1'b1;
      addr_valid_q  <= 1'b0;
      live_q        <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= '0;
      dat_q         <= '0;
      tx_dat_q      <= '0;
      rdat_q        <= '0;
      hi_q          <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      send_q        <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
`ifdef ADDR_CACHE_EN
      last_adr_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      need_resync_q <= need_resync_d;
      addr_valid_q  <= addr_valid_d;
      live_q        <= live_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      tx_dat_q      <= tx_dat_d;
      rdat_q        <= rdat_d;
      hi_q          <= hi_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      send_q        <= send_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
`ifdef ADDR_CACHE_EN
      last_adr_q    <= last_adr_d;
`endif
    end
  end

  assign o_tx_dat    = tx_dat_q;
  assign o_send      = send_q;
  assign wb.o_wb_dat = rdat_q;
  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_err = err_q;

endmodule
